tdc_wsign: RTL
==============

# tdc_wsign

Signed time-to-digital converter: the receiving end of the signed DTC link. On `trig` it latches `din_sign`, counts clock cycles until the DTC pulse arrives on `tdc_in`, and rebuilds the signed sample from magnitude and sign. It sits after the DTC output (on chip loopback or test path) and returns samples to the digital core as `dout` with a one-cycle `dout_valid` strobe.

## Interface
- `WIDTH`, 8: sample width; magnitude counter is WIDTH bits.
- `clk` in 1: single clock, all logic rising-edge.
- `rst` in 1: asynchronous, active-low reset.
- `trig` in 1: one-cycle start strobe, same timing as the DTC's `trig`.
- `din_sign` in 1: sign of the sample; 1 = negative; sampled with `trig`.
- `tdc_in` in 1: DTC output pulse; rising edge ends the measurement.
- `dout` out WIDTH: signed two's-complement reconstructed sample.
- `dout_valid` out 1: one-cycle strobe; `dout` is valid in that cycle.
- `busy` out 1: high while a measurement is in progress.
- `ovf` out 1: high with `dout_valid` when timeout or saturation occurred.

## Operation
- Reset: `dout`=0, `dout_valid`=0, `busy`=0, `ovf`=0, state IDLE, counter 0, sign 0.
- States: IDLE, COUNT, DONE.
- IDLE: on `trig`=1, latch `din_sign`, clear counter, go to COUNT. `busy` rises on the next edge.
- COUNT: counter increments each cycle. On the first sampled rise of `tdc_in`, freeze the magnitude and go to DONE. On counter reaching 2^WIDTH−1 with no rise, go to DONE with `ovf`=1 and magnitude 2^WIDTH−1. `trig` is ignored in COUNT.
- DONE lasts one cycle. `dout_valid`=1 and `busy`=0 in this cycle. If `trig`=1 in DONE, the block latches a new sign and goes to COUNT. Otherwise it goes to IDLE.
- Magnitude N is the number of clock edges from the edge that sampled `trig` to the edge that first samples `tdc_in` high. Synchronizer delay is subtracted internally.
- If `tdc_in` is already high when `trig` is sampled, the level is not an edge. The block waits for a fresh rise, or times out.
- Sign application:
  - Sign 0: `dout` = min(N, 2^(WIDTH−1)−1).
  - Sign 1: `dout` = −min(N, 2^(WIDTH−1)).
  - Either clamp sets `ovf`.
- `dout` holds its value until the next DONE.
- Reset asserted mid-measurement: all outputs go to their reset values immediately and no strobe is emitted.

## Timing
- `trig` sampled at edge T0. `tdc_in` first sampled high at edge T0+N (after compensation). `dout_valid` is high in the cycle after edge T0+N+L, where L is the fixed pipeline latency: L=3 with synchronizer, L=1 without.
- Back-to-back throughput: one sample every N+L+1 cycles minimum, with `trig` in DONE.
- `ovf` is registered alongside `dout`; it is only meaningful while `dout_valid`=1 and otherwise reads 0.

## Configuration
- `TDC_SYNC_EN` defined: `tdc_in` passes through a two-flop synchronizer plus an edge register. Internal compensation subtracts 2, so N is unchanged. L=3.
- `TDC_SYNC_EN` undefined: `tdc_in` is assumed synchronous to `clk`. It is sampled directly by the edge register with no compensation. L=1.

## Structure
- Package `tdc_pkg`: state enum (`TDC_IDLE`, `TDC_COUNT`, `TDC_DONE`) and constant `TDC_SYNC_STAGES` = 2.
- Sub-module `sync_2ff` (`clk`, `rst`, `d`, `q`), instantiated only under `TDC_SYNC_EN`.
- Counter, sign latch, FSM and saturation logic stay in `tdc_wsign`.

## Test plan
- Reset mid-COUNT: assert `rst` low at cycle 5 of a measurement → all outputs 0 at once, IDLE, no `dout_valid`. A new `trig` after release measures normally.
- `trig`, sign 0, `tdc_in` rises 37 cycles later → single `dout_valid`, `dout`=37 (0x25), `ovf`=0, at exactly T0+37+L+1.
- `trig`, sign 1, N=128 → `dout`=−128 (0x80), `ovf`=0. Sign 0, N=128 → `dout`=127 (0x7F), `ovf`=1.
- `trig` with no `tdc_in` edge → after 255 cycles, `dout_valid`=1, `ovf`=1, sign 0 gives `dout`=0x7F.
- `trig` asserted in the DONE cycle with sign 1, next N=5 → first result delivered, second `dout`=−5 (0xFB). A `trig` pulse during COUNT is ignored.
- `tdc_in` held high across `trig`, then low at +3 and high at +10 → `dout`=10, no early strobe.

Source files
------------

// File: rtl/tdc_pkg.sv
// rtl/tdc_pkg.sv - shared state encoding and constants for the signed TDC
package tdc_pkg;

    typedef enum logic [1:0] {
        TDC_IDLE,
        TDC_COUNT,
        TDC_DONE
    } tdc_state_e;

    localparam int TDC_SYNC_STAGES = 2;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for a single asynchronous bit
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/tdc_wsign.sv
// rtl/tdc_wsign.sv - signed time-to-digital converter; TDC_SYNC_EN adds an input synchronizer
module tdc_wsign
    import tdc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trig,
    input  logic             din_sign,
    input  logic             tdc_in,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             ovf
);

`ifdef TDC_SYNC_EN
    localparam int COMP = TDC_SYNC_STAGES;
    logic tdc_s;
    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (tdc_in),
        .q   (tdc_s)
    );
`else
    localparam int COMP = 0;
    logic tdc_s;
    assign tdc_s = tdc_in;
`endif

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] POS_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] NEG_MAG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] COMP_V  = WIDTH'(COMP);

    tdc_state_e       state, state_nx;
    logic [WIDTH-1:0] cnt, cnt_nx;
    logic             sign, sign_nx;
    logic             tdc_prev, rise;
    logic [WIDTH-1:0] dout_nx, mag;
    logic             valid_nx, ovf_nx, finish, timeout;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tdc_prev <= 1'b0;
            rise     <= 1'b0;
        end else begin
            tdc_prev <= tdc_s;
            rise     <= tdc_s & ~tdc_prev;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= TDC_IDLE;
            cnt        <= '0;
            sign       <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            sign       <= sign_nx;
            dout       <= dout_nx;
            dout_valid <= valid_nx;
            ovf        <= ovf_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        sign_nx  = sign;
        dout_nx  = dout;
        valid_nx = 1'b0;
        ovf_nx   = 1'b0;
        finish   = 1'b0;
        timeout  = 1'b0;
        mag      = cnt - COMP_V;
        case (state)
            TDC_IDLE, TDC_DONE: begin
                if (trig) begin
                    sign_nx  = din_sign;
                    cnt_nx   = '0;
                    state_nx = TDC_COUNT;
                end else begin
                    state_nx = TDC_IDLE;
                end
            end
            TDC_COUNT: begin
                cnt_nx = cnt + 1'b1;
                // Rises still in the pipeline from before trig (cnt <= COMP) are stale levels, not edges
                if (rise && (cnt > COMP_V)) begin
                    finish = 1'b1;
                end else if (cnt == CNT_MAX) begin
                    finish  = 1'b1;
                    timeout = 1'b1;
                    mag     = CNT_MAX;
                end
            end
            default: state_nx = TDC_IDLE;
        endcase

        if (finish) begin
            state_nx = TDC_DONE;
            valid_nx = 1'b1;
            ovf_nx   = timeout;
            if (!sign) begin
                if (mag > POS_MAX) begin
                    dout_nx = POS_MAX;
                    ovf_nx  = 1'b1;
                end else begin
                    dout_nx = mag;
                end
            end else begin
                if (mag > NEG_MAG) begin
                    dout_nx = NEG_MAG;
                    ovf_nx  = 1'b1;
                end else begin
                    dout_nx = '0 - mag;
                end
            end
        end
    end

    assign busy = (state == TDC_COUNT);

endmodule
